// File: rtl/rr_requester_4ch_if.sv
// Bundles the producer, arbiter and output-bus signals of the 4-channel round-robin requester.
// The design sits on the slave modport; a producer/arbiter/consumer model sits on the master modport.
interface rr_requester_4ch_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          push_valid_i;
  logic [4*DATA_W-1:0] push_data_i;
  logic [3:0]          push_ready_o;
  logic [3:0]          req_o;
  logic [3:0]          gnt_i;
  logic                out_valid_o;
  logic [1:0]          out_chan_o;
  logic [DATA_W-1:0]   out_data_o;
  logic                err_o;
  logic [3:0]          starve_o;

  modport slave (
    input  push_valid_i, push_data_i, gnt_i,
    output push_ready_o, req_o, out_valid_o, out_chan_o, out_data_o, err_o, starve_o
  );

  modport master (
    output push_valid_i, push_data_i, gnt_i,
    input  push_ready_o, req_o, out_valid_o, out_chan_o, out_data_o, err_o, starve_o
  );
endinterface

// File: rtl/rr_requester_4ch.sv
// Four per-channel FIFOs that request a round-robin arbiter and pop the granted head onto one registered bus.
// Define RR_REQ_STARVE_MON_EN to build the per-channel starvation monitor; otherwise starve_o is tied low.
module rr_requester_4ch #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 15
) (
  input logic                clk,
  input logic                reset,
  rr_requester_4ch_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rr_requester_4ch: DEPTH must be a power of two and at least 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("rr_requester_4ch: STARVE_LIMIT must be at least 1");
  end

  logic [DATA_W-1:0] mem [4][DEPTH];
  logic [AW-1:0]     wr_ptr [4];
  logic [AW-1:0]     rd_ptr [4];
  logic [CW-1:0]     count  [4];

  logic [3:0] req;
  logic [3:0] ready;
  logic [3:0] push;
  logic [3:0] pop;
  logic       gnt_onehot;
  logic       gnt_legal;
  logic       gnt_illegal;
  logic [1:0] gnt_idx;

  logic              out_valid_q;
  logic [1:0]        out_chan_q;
  logic [DATA_W-1:0] out_data_q;
  logic              err_q;

  // Request and ready come from registered counts only, so there is no path gnt_i -> req_o.
  always_comb begin
    req   = '0;
    ready = '0;
    for (int i = 0; i < 4; i++) begin
      req[i]   = (count[i] != '0);
      ready[i] = (count[i] != CW'(DEPTH));
    end
  end

  always_comb begin
    gnt_onehot  = (bus.gnt_i != 4'b0000) && ((bus.gnt_i & (bus.gnt_i - 4'd1)) == 4'b0000);
    gnt_legal   = gnt_onehot && ((bus.gnt_i & req) == bus.gnt_i);
    gnt_illegal = (bus.gnt_i != 4'b0000) && !gnt_legal;
    gnt_idx     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.gnt_i[i]) gnt_idx = 2'(i);
    end
    push = bus.push_valid_i & ready;
    pop  = gnt_legal ? bus.gnt_i : 4'b0000;
  end

  // Storage is not reset; the counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= bus.push_data_i[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Chan/data hold their last value whenever nothing is popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= 2'd0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= gnt_legal;
      if (gnt_legal) begin
        out_chan_q <= gnt_idx;
        out_data_q <= mem[gnt_idx][rd_ptr[gnt_idx]];
      end
      if (gnt_illegal) err_q <= 1'b1;
    end
  end

`ifdef RR_REQ_STARVE_MON_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] wait_cnt [4];
  logic [3:0]    starve;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || pop[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != SW'(STARVE_LIMIT)) begin
          wait_cnt[i] <= wait_cnt[i] + SW'(1);
        end
      end
    end
  end

  always_comb begin
    starve = '0;
    for (int i = 0; i < 4; i++) starve[i] = (wait_cnt[i] == SW'(STARVE_LIMIT));
  end

  assign bus.starve_o = starve;
`else
  assign bus.starve_o = 4'b0000;
`endif

  assign bus.push_ready_o = ready;
  assign bus.req_o        = req;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_chan_o   = out_chan_q;
  assign bus.out_data_o   = out_data_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_rr_requester_4ch.sv
// Directed bench for rr_requester_4ch: grants queue expected {chan,data}, a negedge monitor pops and compares.
// Status outputs (req, ready, err, starve) are checked directly against hand-computed values.
module tb_rr_requester_4ch;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [9:0] exp_q [$];

  rr_requester_4ch_if #(.DATA_W(DATA_W)) bus ();

  rr_requester_4ch #(.DATA_W(DATA_W), .DEPTH(4), .STARVE_LIMIT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef RR_REQ_STARVE_MON_EN
  localparam logic [3:0] STARVE_CH0 = 4'b0001;
`else
  localparam logic [3:0] STARVE_CH0 = 4'b0000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int ch, input logic [7:0] d);
    bus.push_valid_i = 4'b0000;
    bus.push_valid_i[ch] = 1'b1;
    bus.push_data_i[ch*DATA_W +: DATA_W] = d;
    step();
    bus.push_valid_i = 4'b0000;
  endtask

  task automatic grant(input int ch, input logic [7:0] d);
    bus.gnt_i = 4'b0000;
    bus.gnt_i[ch] = 1'b1;
    exp_q.push_back({2'(ch), d});
    step();
    bus.gnt_i = 4'b0000;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {22'd0, bus.out_chan_o, bus.out_data_o}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("pop_chan", {30'd0, bus.out_chan_o}, {30'd0, e[9:8]});
        chk("pop_data", {24'd0, bus.out_data_o}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    bus.push_valid_i = 4'b0000;
    bus.push_data_i  = '0;
    bus.gnt_i        = 4'b0000;
    reset = 1'b1;
    repeat (3) step();
    chk("rst_req", {28'd0, bus.req_o}, 32'h0);
    chk("rst_ready", {28'd0, bus.push_ready_o}, 32'hF);
    chk("rst_out_valid", {31'd0, bus.out_valid_o}, 32'h0);
    chk("rst_out_chan", {30'd0, bus.out_chan_o}, 32'h0);
    chk("rst_out_data", {24'd0, bus.out_data_o}, 32'h0);
    chk("rst_err", {31'd0, bus.err_o}, 32'h0);
    chk("rst_starve", {28'd0, bus.starve_o}, 32'h0);
    reset = 1'b0;
    step();

    // Single push then grant on ch1
    push1(1, 8'hA5);
    chk("single_req", {28'd0, bus.req_o}, 32'h2);
    grant(1, 8'hA5);
    chk("single_out_valid", {31'd0, bus.out_valid_o}, 32'h1);
    chk("single_req_drop", {28'd0, bus.req_o}, 32'h0);
    step();
    chk("single_valid_low", {31'd0, bus.out_valid_o}, 32'h0);
    chk("single_data_hold", {24'd0, bus.out_data_o}, 32'hA5);

    // Fill ch3, refuse a fifth push, drain in order
    for (int k = 1; k <= 4; k++) push1(3, 8'(k));
    chk("full_ready3", {28'd0, bus.push_ready_o}, 32'h7);
    chk("full_req3", {28'd0, bus.req_o}, 32'h8);
    push1(3, 8'h05);
    chk("full_refuse_ready", {28'd0, bus.push_ready_o}, 32'h7);
    for (int k = 1; k <= 4; k++) grant(3, 8'(k));
    chk("drain_req3", {28'd0, bus.req_o}, 32'h0);
    chk("drain_ready", {28'd0, bus.push_ready_o}, 32'hF);

    // Push and pop together while ch0 is full
    for (int k = 0; k < 4; k++) push1(0, 8'h10 + 8'(k));
    bus.push_valid_i = 4'b0001;
    bus.push_data_i[0 +: DATA_W] = 8'h99;
    grant(0, 8'h10);
    bus.push_valid_i = 4'b0000;
    chk("pp_ready0", {28'd0, bus.push_ready_o}, 32'hF);
    chk("pp_req0", {28'd0, bus.req_o}, 32'h1);
    grant(0, 8'h11);
    grant(0, 8'h12);
    grant(0, 8'h13);
    chk("pp_drained", {28'd0, bus.req_o}, 32'h0);

    // Starvation on ch0
    push1(0, 8'h5A);
    repeat (14) step();
    chk("starve_before", {28'd0, bus.starve_o}, 32'h0);
    step();
    chk("starve_at_limit", {28'd0, bus.starve_o}, {28'd0, STARVE_CH0});
    step();
    chk("starve_saturated", {28'd0, bus.starve_o}, {28'd0, STARVE_CH0});
    grant(0, 8'h5A);
    chk("starve_cleared", {28'd0, bus.starve_o}, 32'h0);

    // Illegal grants
    bus.push_valid_i = 4'b0110;
    bus.push_data_i[1*DATA_W +: DATA_W] = 8'h21;
    bus.push_data_i[2*DATA_W +: DATA_W] = 8'h22;
    step();
    bus.push_valid_i = 4'b0000;
    chk("ill_err_pre", {31'd0, bus.err_o}, 32'h0);
    bus.gnt_i = 4'b0110;
    step();
    bus.gnt_i = 4'b0000;
    chk("ill_multi_err", {31'd0, bus.err_o}, 32'h1);
    chk("ill_multi_valid", {31'd0, bus.out_valid_o}, 32'h0);
    chk("ill_multi_req", {28'd0, bus.req_o}, 32'h6);
    step();
    chk("ill_err_sticky", {31'd0, bus.err_o}, 32'h1);
    bus.gnt_i = 4'b1000;
    step();
    bus.gnt_i = 4'b0000;
    chk("ill_empty_err", {31'd0, bus.err_o}, 32'h1);
    chk("ill_empty_valid", {31'd0, bus.out_valid_o}, 32'h0);
    chk("ill_empty_req", {28'd0, bus.req_o}, 32'h6);

    // Reset mid-traffic with ch2 holding 3 entries
    push1(2, 8'h23);
    push1(2, 8'h24);
    chk("pre_rst_req", {28'd0, bus.req_o}, 32'h6);
    bus.push_valid_i = 4'b0100;
    reset = 1'b1;
    step();
    chk("mid_rst_req", {28'd0, bus.req_o}, 32'h0);
    chk("mid_rst_ready", {28'd0, bus.push_ready_o}, 32'hF);
    chk("mid_rst_valid", {31'd0, bus.out_valid_o}, 32'h0);
    chk("mid_rst_err", {31'd0, bus.err_o}, 32'h0);
    bus.push_valid_i = 4'b0000;
    reset = 1'b0;
    step();
    chk("post_rst_req", {28'd0, bus.req_o}, 32'h0);

    // Back-to-back pops across channels after reset
    push1(2, 8'h31);
    push1(1, 8'h41);
    grant(2, 8'h31);
    grant(1, 8'h41);
    step();
    chk("final_req", {28'd0, bus.req_o}, 32'h0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rr_requester_4ch.md
# rr_requester_4ch

Requester-side front end for the 4-port round-robin arbiter. It buffers transactions from four independent producers in per-channel FIFOs and drives `req_o` to the arbiter while each FIFO is non-empty. When the one-hot grant `gnt_i` arrives, it pops the granted channel's head entry onto a single registered output bus. It also checks grant legality and, optionally, monitors per-channel starvation.

## Interface
- `DATA_W`, default 8: payload width per transaction.
- `DEPTH`, default 4: entries per channel FIFO. Power of two, ≥2.
- `STARVE_LIMIT`, default 15: wait-cycle threshold for starvation flag. Must be ≥1.

- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `push_valid_i`  in  4  per-channel push request.
- `push_data_i`  in  4*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
- `push_ready_o`  out  4  per-channel FIFO not full.
- `req_o`  out  4  to arbiter; bit i = channel i FIFO non-empty.
- `gnt_i`  in  4  from arbiter; one-hot or zero.
- `out_valid_o`  out  1  popped transaction valid this cycle.
- `out_chan_o`  out  2  channel index of popped transaction.
- `out_data_o`  out  DATA_W  popped payload.
- `err_o`  out  1  sticky illegal-grant flag.
- `starve_o`  out  4  per-channel starvation flag. Constant 0 unless `RR_REQ_STARVE_MON_EN` is defined.

## Operation
- **FIFOs:** four identical FIFOs, each with its own write pointer, read pointer and occupancy count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- **Push:** accepted on channel i at a clock edge when `push_valid_i[i] & push_ready_o[i]`. `push_ready_o[i] = (count_i != DEPTH)`, decoded combinationally from registered count.
  - No bypass: a full FIFO refuses a push even in a cycle where it is also popped.
- **Request:** `req_o[i] = (count_i != 0)`, decoded from registered state only. There is no combinational path from `gnt_i` to `req_o`, so there is no loop through the arbiter.
- **Grant legality:** a grant is legal when `gnt_i` is one-hot and `req_o` has the same bit set.
  - Legal grant on channel i: pop channel i's head. Next cycle, `out_valid_o=1`, `out_chan_o=i`, `out_data_o`=head entry.
  - `gnt_i == 0`: no pop; `out_valid_o=0` next cycle.
  - Illegal grant (multi-hot, or granting a channel with `req_o` low): no pop on any channel, `out_valid_o=0` next cycle, `err_o` set. `err_o` stays set until reset.
- **Simultaneous events:** push and pop on the same channel in one cycle leaves the count unchanged. Pushes on other channels are independent of the pop.
- **Output bus:** `out_valid_o`, `out_chan_o` and `out_data_o` are registered. When `out_valid_o=0`, `out_chan_o` and `out_data_o` hold their last values.
- **Reset mid-operation:** all FIFO contents are discarded. Pointers and counts return to 0; pushes while `reset` is high are dropped.

## Timing
- **Reset values:**
  - `req_o=0`, `out_valid_o=0`, `out_chan_o=0`, `out_data_o=0`, `err_o=0`, `starve_o=0`.
  - `push_ready_o=4'b1111`.
- **Push to request:** a push into an empty FIFO at edge N raises `req_o[i]` after edge N, i.e. in cycle N+1.
- **Grant to output:** 1 cycle. `gnt_i` is sampled at edge N; `out_valid_o` and data are visible after edge N.
- **Last entry popped:** when the last entry is popped at edge N, `req_o[i]` drops after edge N.
- **Throughput:** up to one pop per cycle across all channels. A single channel can be popped on consecutive cycles.

## Configuration
- **`RR_REQ_STARVE_MON_EN` defined:**
  - Each channel has a saturating wait counter of width clog2(STARVE_LIMIT+1).
  - The counter increments on each edge where `req_o[i]=1` and channel i is not legally granted.
  - The counter clears to 0 on a legal grant to channel i, or when `req_o[i]=0`.
  - The counter saturates at STARVE_LIMIT.
  - `starve_o[i] = (cnt_i == STARVE_LIMIT)`, registered-state decode.
- **Not defined:** no counters are built and `starve_o` is tied to 4'b0000.

## Test plan
- **Reset state:** assert `reset` mid-traffic with channel 2 holding 3 entries → next cycle `req_o=0`, `push_ready_o=4'b1111`, `out_valid_o=0`, `err_o=0`.
- **Single push/grant:** push 0xA5 on ch1; one cycle later drive `gnt_i=4'b0010` → `req_o=4'b0010` in the cycle after the push, `out_valid_o=1`, `out_chan_o=1`, `out_data_o=0xA5` one cycle after the grant, then `req_o=0`.
- **Full / ordering:** push 0x01..0x04 on ch3 with DEPTH=4 → `push_ready_o[3]=0` and a fifth push (0x05) is refused. Four grants to ch3 yield 0x01, 0x02, 0x03, 0x04 in order, then `req_o[3]=0`.
- **Push and pop while full:** with ch0 full, drive a push and `gnt_i=4'b0001` in the same cycle → push refused, count becomes 3, `push_ready_o[0]=1` next cycle.
- **Illegal grants:** drive `gnt_i=4'b0110` with ch1 and ch2 both requesting → no pop, `out_valid_o=0`, `err_o=1` and it stays 1. Then drive `gnt_i=4'b1000` with ch3 empty → no pop, `err_o` remains 1.
- **Starvation (macro defined, STARVE_LIMIT=15):** keep ch0 requesting and ungranted for 15 cycles → `starve_o[0]=1` from cycle 15. A legal grant to ch0 clears it the next cycle. Without the macro, `starve_o` stays 0.
